// File: rtl/multicycle_control.sv
// Control sequencer for the shared multicycle RV datapath (R-type, ld, sd, beq).
// It drives the datapath enables and selects, counts retired instructions and raises a sticky illegal-opcode trap.
//
// state   | meaning
// --------+---------------------------------------------------------
// FETCH   | read instruction at PC, load IR and PC+4 on mem_ready
// DECODE  | dispatch on opcode, precompute branch target into ALUOut
// MEMADDR | compute rs1 + imm effective address
// MEM_RD  | load data read, wait for mem_ready
// MEM_WB  | write MDR to register file
// MEM_WR  | store data write, wait for mem_ready
// EXEC_R  | funct-decoded ALU operation on rs1/rs2
// R_WB    | write ALUOut to register file
// BRANCH  | compare rs1/rs2, conditional PC load from ALUOut
// TRAP    | illegal opcode, parked until reset
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             pc_source,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             illegal,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state_dbg
);

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_SD = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADDR = 4'd2,
      MEM_RD  = 4'd3,
      MEM_WB  = 4'd4,
      MEM_WR  = 4'd5,
      EXEC_R  = 4'd6,
      R_WB    = 4'd7,
      BRANCH  = 4'd8,
      TRAP    = 4'd9
   } state_t;

   state_t state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FETCH;
         retired <= '0;
         illegal <= 1'b0;
      end else begin
         case (state)
            FETCH:   if (mem_ready) state <= DECODE;
            DECODE: begin
               case (opcode)
                  OP_R:         state <= EXEC_R;
                  OP_LD, OP_SD: state <= MEMADDR;
                  OP_BR:        state <= BRANCH;
                  default: begin
                     state   <= TRAP;
                     illegal <= 1'b1;
                  end
               endcase
            end
            MEMADDR: state <= (opcode == OP_LD) ? MEM_RD : MEM_WR;
            MEM_RD:  if (mem_ready) state <= MEM_WB;
            MEM_WB: begin
               state   <= FETCH;
               retired <= retired + CNT_W'(1);
            end
            MEM_WR: begin
               if (mem_ready) begin
                  state   <= FETCH;
                  retired <= retired + CNT_W'(1);
               end
            end
            EXEC_R:  state <= R_WB;
            R_WB, BRANCH: begin
               state   <= FETCH;
               retired <= retired + CNT_W'(1);
            end
            TRAP:    state <= TRAP;
            default: state <= FETCH;
         endcase
      end
   end

   // Decoded from state and gated by reset so requests drop without waiting for a clock edge.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      if (!reset) begin
         case (state)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            DECODE: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b10;
            end
            MEMADDR: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
            end
            MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEM_WR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            EXEC_R: begin
               alu_src_a = 2'b01;
               alu_op    = 2'b10;
            end
            R_WB:    reg_write = 1'b1;
            BRANCH: begin
               alu_src_a     = 2'b01;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, stalls, trap and mid-wait reset.
module tb_multicycle_control;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_SD = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  opcode;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
   logic        ir_write, mem_to_reg, reg_write, illegal;
   logic [1:0]  alu_src_a, alu_src_b, alu_op;
   logic [31:0] retired;
   logic [3:0]  state_dbg;
   logic [14:0] ctl;

   int errors = 0;
   int checks = 0;

   multicycle_control #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .illegal(illegal), .retired(retired), .state_dbg(state_dbg)
   );

   assign ctl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                 ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic adv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b1;
      opcode    = OP_R;
      #1;
      check("rst_ctl", 32'(ctl), 32'h0);
      check("rst_state", 32'(state_dbg), 32'd0);
      check("rst_retired", retired, 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      adv;
      adv;
      reset = 1'b0;
      #1;

      // R-type: 0,1,6,7,0
      check("r_fetch_state", 32'(state_dbg), 32'd0);
      check("r_fetch_ctl", 32'(ctl), 32'b1_0_0_0_1_0_1_0_0_00_01_00);
      adv;
      check("r_dec_state", 32'(state_dbg), 32'd1);
      check("r_dec_ctl", 32'(ctl), 32'b0_0_0_0_0_0_0_0_0_10_10_00);
      adv;
      check("r_exec_state", 32'(state_dbg), 32'd6);
      check("r_exec_ctl", 32'(ctl), 32'b0_0_0_0_0_0_0_0_0_01_00_10);
      adv;
      check("r_wb_state", 32'(state_dbg), 32'd7);
      check("r_wb_ctl", 32'(ctl), 32'b0_0_0_0_0_0_0_0_1_00_00_00);
      adv;
      check("r_done_state", 32'(state_dbg), 32'd0);
      check("r_retired", retired, 32'd1);

      // ld with two stall cycles in MEM_RD: 0,1,2,3,3,3,4,0
      opcode = OP_LD;
      adv;
      check("ld_dec_state", 32'(state_dbg), 32'd1);
      adv;
      check("ld_addr_state", 32'(state_dbg), 32'd2);
      check("ld_addr_ctl", 32'(ctl), 32'b0_0_0_0_0_0_0_0_0_01_10_00);
      adv;
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) mem_ready = 1'b1;
         #1;
         check("ld_rd_state", 32'(state_dbg), 32'd3);
         check("ld_rd_ctl", 32'(ctl), 32'b0_0_0_1_1_0_0_0_0_00_00_00);
         adv;
      end
      check("ld_wb_state", 32'(state_dbg), 32'd4);
      check("ld_wb_ctl", 32'(ctl), 32'b0_0_0_0_0_0_0_1_1_00_00_00);
      check("ld_wb_retired", retired, 32'd1);
      adv;
      check("ld_done_state", 32'(state_dbg), 32'd0);
      check("ld_retired", retired, 32'd2);

      // sd then beq back to back, 7 cycles total
      opcode = OP_SD;
      #1;
      check("sd_fetch_memwrite", 32'(mem_write), 32'd0);
      adv;
      adv;
      check("sd_addr_state", 32'(state_dbg), 32'd2);
      adv;
      check("sd_wr_state", 32'(state_dbg), 32'd5);
      check("sd_wr_ctl", 32'(ctl), 32'b0_0_0_1_0_1_0_0_0_00_00_00);
      adv;
      opcode = OP_BR;
      #1;
      check("sd_done_state", 32'(state_dbg), 32'd0);
      check("sd_retired", retired, 32'd3);
      check("beq_fetch_memwrite", 32'(mem_write), 32'd0);
      adv;
      check("beq_dec_state", 32'(state_dbg), 32'd1);
      adv;
      check("beq_state", 32'(state_dbg), 32'd8);
      check("beq_ctl", 32'(ctl), 32'b0_1_1_0_0_0_0_0_0_01_00_01);
      adv;
      check("beq_done_state", 32'(state_dbg), 32'd0);
      check("beq_retired", retired, 32'd4);

      // FETCH stalled three cycles, then one IR/PC load pulse
      opcode    = OP_R;
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_state", 32'(state_dbg), 32'd0);
         check("stall_irpc", {30'd0, ir_write, pc_write}, 32'd0);
         check("stall_memread", 32'(mem_read), 32'd1);
         adv;
      end
      mem_ready = 1'b1;
      #1;
      check("stall_pulse", {30'd0, ir_write, pc_write}, 32'd3);
      adv;
      check("stall_after_state", 32'(state_dbg), 32'd1);
      check("stall_after_irpc", {30'd0, ir_write, pc_write}, 32'd0);
      adv;
      adv;
      adv;
      check("stall_r_state", 32'(state_dbg), 32'd0);
      check("stall_r_retired", retired, 32'd5);

      // Illegal opcode parks in TRAP
      opcode = OP_BAD;
      adv;
      check("trap_dec_illegal", 32'(illegal), 32'd0);
      adv;
      check("trap_state", 32'(state_dbg), 32'd9);
      check("trap_illegal", 32'(illegal), 32'd1);
      check("trap_ctl", 32'(ctl), 32'd0);
      for (int i = 0; i < 20; i++) begin
         mem_ready = i[0];
         opcode    = (i[1]) ? OP_R : OP_LD;
         adv;
      end
      check("trap_hold_state", 32'(state_dbg), 32'd9);
      check("trap_hold_ctl", 32'(ctl), 32'd0);
      check("trap_hold_illegal", 32'(illegal), 32'd1);
      check("trap_retired", retired, 32'd5);
      reset = 1'b1;
      #1;
      check("trap_rst_illegal", 32'(illegal), 32'd0);
      check("trap_rst_state", 32'(state_dbg), 32'd0);
      adv;
      reset     = 1'b0;
      mem_ready = 1'b1;

      // Reset while waiting in MEM_WR
      opcode = OP_SD;
      #1;
      check("abort_retired0", retired, 32'd0);
      adv;
      adv;
      adv;
      mem_ready = 1'b0;
      #1;
      check("abort_wr_state", 32'(state_dbg), 32'd5);
      check("abort_wr_memwrite", 32'(mem_write), 32'd1);
      adv;
      check("abort_wr_hold", 32'(state_dbg), 32'd5);
      reset = 1'b1;
      #1;
      check("abort_memwrite_drop", 32'(mem_write), 32'd0);
      check("abort_ctl_drop", 32'(ctl), 32'd0);
      adv;
      reset = 1'b0;
      #1;
      check("abort_restart_state", 32'(state_dbg), 32'd0);
      check("abort_retired", retired, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the shared multicycle RV datapath: one ALU, one unified memory, IR/MDR/ALUOut latches.
- Supports the R-type (add/sub/and/or), ld, sd and beq subset.
- Takes the IR opcode and a memory-ready handshake; drives every datapath enable and mux select.
- Also keeps a retired-instruction counter and a sticky illegal-opcode trap.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  7  IR[6:0]; valid from the DECODE state onward.
- mem_ready  input  1  memory completes the current read or write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load qualified by the ALU zero flag (external AND).
- pc_source  output  1  0 = ALU result, 1 = ALUOut.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load.
- mem_to_reg  output  1  register write-back source: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register-file write enable.
- alu_src_a  output  2  00 = PC, 01 = rs1 latch, 10 = oldPC.
- alu_src_b  output  2  00 = rs2 latch, 01 = constant 4, 10 = immediate.
- alu_op  output  2  00 = add, 01 = subtract/compare, 10 = funct-decoded.
- illegal  output  1  sticky trap flag.
- retired  output  CNT_W  count of completed instructions.
- state_dbg  output  4  current state encoding.

Behaviour:
- Reset (async):
  - State goes to FETCH (0); retired = 0; illegal = 0.
  - While reset is high, every enable, request and select output is forced to 0.
- State encodings: FETCH 0, DECODE 1, MEMADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, BRANCH 8, TRAP 9.
- Outputs not listed for a state are 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=0.
  - ir_write = pc_write = mem_ready (the only combinationally qualified outputs).
  - If mem_ready: go to DECODE. Otherwise stay in FETCH, holding all outputs.
- DECODE:
  - Drives alu_src_a=10, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 0110011 -> EXEC_R; 0000011 or 0100011 -> MEMADDR; 1100011 -> BRANCH; any other opcode -> TRAP.
- MEMADDR:
  - Drives alu_src_a=01, alu_src_b=10, alu_op=00.
  - Re-samples opcode: 0000011 -> MEM_RD, otherwise -> MEM_WR.
- MEM_RD:
  - Drives mem_read=1, i_or_d=1.
  - Waits on mem_ready, then goes to MEM_WB.
- MEM_WB:
  - Drives reg_write=1, mem_to_reg=1.
  - Next state FETCH; retire.
- MEM_WR:
  - Drives mem_write=1, i_or_d=1.
  - Waits on mem_ready, then goes to FETCH; retire on the exit edge.
- EXEC_R:
  - Drives alu_src_a=01, alu_src_b=00, alu_op=10.
  - Next state R_WB.
- R_WB:
  - Drives reg_write=1, mem_to_reg=0.
  - Next state FETCH; retire.
- BRANCH:
  - Drives alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1.
  - Next state FETCH; retire, whether or not the branch is taken.
- TRAP:
  - All enables 0; illegal=1; state is held until reset.
  - retired stops counting.
- Retire rule:
  - retired increments by 1 on the edge that leaves MEM_WB, MEM_WR (with mem_ready), R_WB or BRANCH.
  - Wraps from 2^CNT_W - 1 to 0 with no flag.
- Latency with mem_ready held at 1:
  - R-type 4 cycles, ld 5, sd 4, beq 3.
  - Each cycle mem_ready stays low in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_read and mem_write are never asserted in the same cycle.
- reg_write and pc_write are never asserted in the same cycle.
- mem_ready is ignored in every state except FETCH, MEM_RD and MEM_WR.
- Reset asserted mid-wait (e.g. in MEM_RD with mem_ready low):
  - Requests drop immediately (asynchronously).
  - Restart is in FETCH; no retire is counted for the aborted instruction.

Test Plan:
- Reset, then release with mem_ready=1 and opcode=0110011 -> state_dbg sequence 0,1,6,7,0; reg_write high only in cycle 4 with mem_to_reg=0; retired = 1.
- ld (0000011), mem_ready low for 2 cycles in MEM_RD -> sequence 0,1,2,3,3,3,4,0; mem_read high and i_or_d=1 throughout MEM_RD; reg_write with mem_to_reg=1 in MEM_WB; retired +1.
- sd (0100011) then beq (1100011) back-to-back with mem_ready=1 -> sd: mem_write in state 5 only; beq: pc_write_cond=1, alu_op=01, pc_source=1 in state 8; retired +2 after 7 cycles.
- FETCH with mem_ready low for 3 cycles -> ir_write and pc_write stay 0, then both pulse together for exactly one cycle.
- Opcode 1111111 at DECODE -> TRAP (9); illegal=1; all enables 0; state held for 20 cycles; retired unchanged; reset clears illegal.
- Assert reset while in MEM_WR with mem_ready=0 -> mem_write drops to 0 before the next clk edge; after release, state_dbg=0; retired=0.
